// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory responder slice.
//   state_t  : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W   : data word width in bits
//   BE_W     : number of byte enables per word
//   addr_err : flags a byte address that is misaligned or beyond the
//              stored range; kept here so an MMIO decoder can share it
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // True when the byte address is not word aligned or falls at or past
    // depth*4 bytes. The limit is widened to 34 bits so a depth that
    // covers the whole 32-bit space cannot wrap to zero.
    function automatic logic addr_err(input logic [31:0] addr, input int depth);
        logic [33:0] limit;
        limit = 34'(unsigned'(depth)) << 2;
        return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: DEPTH x 32-bit storage with per-byte write enables and a
// registered read port. Contents are never cleared.
//   clk   : rising-edge clock
//   we    : write strobe, bytes selected by be
//   be    : byte enables, bit i covers wdata[8i+7:8i]
//   addr  : word index shared by read and write
//   wdata : write data
//   re    : read strobe, captures mem[addr] into rdata
//   rdata : registered read data, holds until the next read strobe
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's load/store port.
// Accepts one request at a time, waits WAIT_STATES cycles, then commits a
// byte-enabled store or captures load data and presents the response until
// the requester takes it. Misaligned or out-of-range addresses get rsp_err.
//   clk, reset          : clock and synchronous active-high reset
//   req_valid/req_ready : request handshake
//   req_we              : 1 = store, 0 = load
//   req_addr            : byte address
//   req_be, req_wdata   : store byte enables and data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data, 0 for stores and errors
//   rsp_err             : access error
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [BE_W-1:0]   req_be,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    state_t state, state_next;
    logic [3:0] wait_cnt;

    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [BE_W-1:0]   lat_be;
    logic [WORD_W-1:0] lat_wdata;

    logic rsp_err_q;
    logic rsp_load_q;

    logic accept;
    logic commit;
    logic              cm_we;
    logic [31:0]       cm_addr;
    logic [BE_W-1:0]   cm_be;
    logic [WORD_W-1:0] cm_wdata;
    logic              cm_err;
    logic [WORD_W-1:0] bank_rdata;

    assign accept = (state == IDLE) && req_valid && !reset;

    // With zero wait states the commit edge is the acceptance edge, so the
    // live request is used; otherwise the copy latched at acceptance.
    assign cm_we    = (state == IDLE) ? req_we    : lat_we;
    assign cm_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign cm_be    = (state == IDLE) ? req_be    : lat_be;
    assign cm_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign cm_err   = addr_err(cm_addr, DEPTH);

    // Commit happens on the edge that enters RESP; reset suppresses it.
    assign commit = !reset &&
                    ((accept && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && (wait_cnt == 4'd1)));

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            rsp_err_q  <= 1'b0;
            rsp_load_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_be    <= req_be;
                lat_wdata <= req_wdata;
                wait_cnt  <= 4'(WAIT_STATES);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                rsp_err_q  <= cm_err;
                rsp_load_q <= !cm_we && !cm_err;
            end
        end
    end

    // The bank read register only updates on a load commit, so the data
    // stays stable for as long as the response is held.
    assign rsp_rdata = rsp_load_q ? bank_rdata : '0;
    assign rsp_err   = rsp_err_q;

    dmem_bank #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .we    (commit && cm_we && !cm_err),
        .be    (cm_be),
        .addr  (cm_addr[ADDR_W+1:2]),
        .wdata (cm_wdata),
        .re    (commit && !cm_we && !cm_err),
        .rdata (bank_rdata)
    );

endmodule
